pipe_stage_reg: RTL and testbench

Parametrised elastic pipeline register replacing the fixed, always-advancing inter-stage registers (EX/MEM first, then ID/EX and MEM/WB). It carries a configurable bundle of data words, a destination register index and a control vector. It adds a valid/ready handshake with a two-entry skid buffer, a synchronous flush, and occupancy reporting, so that stalls and squashes are handled inside the stage rather than by upstream gating.

---
 rtl/pipe_stage_reg_pkg.sv | 14 +
 rtl/pipe_stage_reg_if.sv | 33 +++
 rtl/pipe_stage_reg_slot.sv | 21 ++
 rtl/pipe_stage_reg.sv | 101 ++++++++++
 tb/tb_pipe_stage_reg.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/pipe_stage_reg_pkg.sv
// pipeline_pkg: shared state and occupancy encodings for the elastic stage registers
// (EX/MEM now, later ID/EX and MEM/WB).
//   stage_state_t : EMPTY (no entries), ONE (main slot only), FULL (main + skid)
//   OCC_*         : occupancy_o encodings
//   occ_of()      : occupancy held in a given state
package pipeline_pkg;
    typedef enum logic [1:0] {EMPTY, ONE, FULL} stage_state_t;
    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_FULL  = 2'd2;
    function automatic logic [1:0] occ_of(stage_state_t s);
        return s == FULL ? OCC_FULL : s == ONE ? OCC_ONE : OCC_EMPTY;
    endfunction
endpackage

// File: rtl/pipe_stage_reg_if.sv
// pipe_stage_reg_if: handshake and payload bundle of one elastic pipeline stage.
//   upstream   : flush_i, valid_i, ready_o, data_i, rd_i, ctrl_i
//   downstream : valid_o, ready_i, data_o, rd_o, ctrl_o
//   status     : occupancy_o
//   slave  modport = the stage itself, master modport = the surrounding pipeline.
interface pipe_stage_reg_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_DATA       = 4,
    parameter int REGISTER_WIDTH = 5,
    parameter int CTRL_WIDTH     = 6
);
    logic                           flush_i;
    logic                           valid_i;
    logic                           ready_o;
    logic [NUM_DATA*DATA_WIDTH-1:0] data_i;
    logic [REGISTER_WIDTH-1:0]      rd_i;
    logic [CTRL_WIDTH-1:0]          ctrl_i;
    logic                           valid_o;
    logic                           ready_i;
    logic [NUM_DATA*DATA_WIDTH-1:0] data_o;
    logic [REGISTER_WIDTH-1:0]      rd_o;
    logic [CTRL_WIDTH-1:0]          ctrl_o;
    logic [1:0]                     occupancy_o;

    modport slave (
        input  flush_i, valid_i, data_i, rd_i, ctrl_i, ready_i,
        output ready_o, valid_o, data_o, rd_o, ctrl_o, occupancy_o
    );
    modport master (
        output flush_i, valid_i, data_i, rd_i, ctrl_i, ready_i,
        input  ready_o, valid_o, data_o, rd_o, ctrl_o, occupancy_o
    );
endinterface

// File: rtl/pipe_stage_reg_slot.sv
// pipe_slot: enable-loaded payload register {data, rd, ctrl} with async active-low reset.
//   clk, rst_ni : clock, asynchronous active-low reset
//   ld, d       : load enable and next payload
//   clr         : zero the slot (only when CLEAR is set; otherwise the payload is held)
//   q           : stored payload
module pipe_slot #(
    parameter int W     = 1,
    parameter bit CLEAR = 1'b1
) (
    input  logic         clk,
    input  logic         rst_ni,
    input  logic         ld,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or negedge rst_ni)
        if (!rst_ni)           q <= '0;
        else if (CLEAR && clr) q <= '0;
        else if (ld)           q <= d;
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: elastic pipeline register with a two-entry skid buffer, flush and occupancy.
//   clk, rst_ni : clock, asynchronous active-low reset
//   bus (slave) : upstream valid/ready + payload, downstream valid/ready + payload,
//                 synchronous flush_i and occupancy_o
module pipe_stage_reg
    import pipeline_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_DATA       = 4,
    parameter int REGISTER_WIDTH = 5,
    parameter int CTRL_WIDTH     = 6,
    parameter bit CLEAR_PAYLOAD  = 1'b1
) (
    input logic            clk,
    input logic            rst_ni,
    pipe_stage_reg_if.slave bus
);
    localparam int DW = NUM_DATA * DATA_WIDTH;
    localparam int W  = DW + REGISTER_WIDTH + CTRL_WIDTH;

    stage_state_t          state_q, state_d;
    logic                  valid_q, ready_q;
    logic [1:0]            occ_q;
    logic                  in_fire, out_fire;
    logic                  main_ld, main_from_skid, main_clr, skid_ld, skid_clr;
    logic [W-1:0]          in_pl, main_d, main_q, skid_q;
    logic [CTRL_WIDTH-1:0] ctrl_q;

    assign in_fire  = bus.valid_i & ready_q;
    assign out_fire = valid_q & bus.ready_i;
    assign in_pl    = {bus.data_i, bus.rd_i, bus.ctrl_i};
    assign main_d   = main_from_skid ? skid_q : in_pl;

    always_comb begin
        state_d        = state_q;
        main_ld        = 1'b0;
        main_from_skid = 1'b0;
        main_clr       = 1'b0;
        skid_ld        = 1'b0;
        skid_clr       = 1'b0;
        if (bus.flush_i) begin
            state_d  = EMPTY;
            main_clr = 1'b1;
            skid_clr = 1'b1;
        end else begin
            case (state_q)
                EMPTY: if (in_fire) begin
                    main_ld = 1'b1;
                    state_d = ONE;
                end
                ONE: if (in_fire && out_fire) begin
                    main_ld = 1'b1;
                end else if (in_fire) begin
                    skid_ld = 1'b1;
                    state_d = FULL;
                end else if (out_fire) begin
                    main_clr = 1'b1;
                    state_d  = EMPTY;
                end
                FULL: if (out_fire) begin
                    main_ld        = 1'b1;
                    main_from_skid = 1'b1;
                    skid_clr       = 1'b1;
                    state_d        = ONE;
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // Status outputs are registered from the next state so they leave the stage straight from flops.
    always_ff @(posedge clk or negedge rst_ni)
        if (!rst_ni) begin
            state_q <= EMPTY;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            occ_q   <= OCC_EMPTY;
        end else begin
            state_q <= state_d;
            valid_q <= state_d != EMPTY;
            ready_q <= state_d != FULL;
            occ_q   <= occ_of(state_d);
        end

    pipe_slot #(.W(W), .CLEAR(CLEAR_PAYLOAD)) u_main (
        .clk(clk), .rst_ni(rst_ni), .ld(main_ld), .clr(main_clr), .d(main_d), .q(main_q)
    );

    pipe_slot #(.W(W), .CLEAR(CLEAR_PAYLOAD)) u_skid (
        .clk(clk), .rst_ni(rst_ni), .ld(skid_ld), .clr(skid_clr), .d(in_pl), .q(skid_q)
    );

    assign ctrl_q          = main_q[CTRL_WIDTH-1:0];
    assign bus.data_o      = main_q[W-1 -: DW];
    assign bus.rd_o        = main_q[CTRL_WIDTH +: REGISTER_WIDTH];
    // Bubbles never carry live control bits, even when stale payload is held.
    assign bus.ctrl_o      = ctrl_q & {CTRL_WIDTH{valid_q}};
    assign bus.valid_o     = valid_q;
    assign bus.ready_o     = ready_q;
    assign bus.occupancy_o = occ_q;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed bench for pipe_stage_reg (clearing instance plus a stale-payload instance).
module tb_pipe_stage_reg;
    logic clk = 1'b0;
    logic rst_ni;
    int   passed = 0;
    int   failed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    pipe_stage_reg_if bus ();
    pipe_stage_reg_if bus2 ();

    pipe_stage_reg dut (.clk(clk), .rst_ni(rst_ni), .bus(bus));
    pipe_stage_reg #(.CLEAR_PAYLOAD(1'b0)) dut_hold (.clk(clk), .rst_ni(rst_ni), .bus(bus2));

    assign bus2.flush_i = bus.flush_i;
    assign bus2.valid_i = bus.valid_i;
    assign bus2.data_i  = bus.data_i;
    assign bus2.rd_i    = bus.rd_i;
    assign bus2.ctrl_i  = bus.ctrl_i;
    assign bus2.ready_i = bus.ready_i;

    function automatic logic [127:0] dat(int n);
        return {32'(n + 3000), 32'(n + 2000), 32'(n + 1000), 32'(n)};
    endfunction

    function automatic logic [5:0] ctl(int n);
        return 6'(n) | 6'h20;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic put(int n);
        bus.valid_i = 1'b1;
        bus.data_i  = dat(n);
        bus.rd_i    = 5'(n);
        bus.ctrl_i  = ctl(n);
    endtask

    task automatic idle();
        bus.valid_i = 1'b0;
        bus.data_i  = '0;
        bus.rd_i    = '0;
        bus.ctrl_i  = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_valid"}, 128'(bus.valid_o), 128'(0));
        chk({tag, "_ready"}, 128'(bus.ready_o), 128'(1));
        chk({tag, "_occ"}, 128'(bus.occupancy_o), 128'(0));
        chk({tag, "_data"}, bus.data_o, 128'(0));
        chk({tag, "_rd"}, 128'(bus.rd_o), 128'(0));
        chk({tag, "_ctrl"}, 128'(bus.ctrl_o), 128'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1, "timeout");
    end

    initial begin
        rst_ni      = 1'b0;
        bus.flush_i = 1'b0;
        bus.ready_i = 1'b1;
        idle();
        tick();
        tick();
        chk_reset("rst_held");
        rst_ni = 1'b1;
        tick();
        chk_reset("rst_released");

        for (int n = 1; n <= 8; n++) begin
            put(n);
            tick();
            chk($sformatf("stream%0d_valid", n), 128'(bus.valid_o), 128'(1));
            chk($sformatf("stream%0d_rd", n), 128'(bus.rd_o), 128'(n));
            chk($sformatf("stream%0d_data", n), bus.data_o, dat(n));
            chk($sformatf("stream%0d_ctrl", n), 128'(bus.ctrl_o), 128'(ctl(n)));
            chk($sformatf("stream%0d_occ", n), 128'(bus.occupancy_o), 128'(1));
        end
        idle();
        tick();
        chk("drain_valid", 128'(bus.valid_o), 128'(0));
        chk("drain_occ", 128'(bus.occupancy_o), 128'(0));
        chk("drain_data_cleared", bus.data_o, 128'(0));
        chk("drain_ctrl", 128'(bus.ctrl_o), 128'(0));
        chk("hold_stale_rd", 128'(bus2.rd_o), 128'(8));
        chk("hold_bubble_ctrl", 128'(bus2.ctrl_o), 128'(0));
        chk("hold_valid", 128'(bus2.valid_o), 128'(0));

        put(3);
        tick();
        chk("bp_rd3", 128'(bus.rd_o), 128'(3));
        chk("bp_occ1", 128'(bus.occupancy_o), 128'(1));
        bus.ready_i = 1'b0;
        put(4);
        tick();
        chk("bp_occ2", 128'(bus.occupancy_o), 128'(2));
        chk("bp_ready0", 128'(bus.ready_o), 128'(0));
        chk("bp_hold_rd3", 128'(bus.rd_o), 128'(3));
        put(5);
        tick();
        chk("bp2_occ2", 128'(bus.occupancy_o), 128'(2));
        chk("bp2_hold_rd3", 128'(bus.rd_o), 128'(3));
        chk("bp2_valid", 128'(bus.valid_o), 128'(1));
        bus.ready_i = 1'b1;
        tick();
        chk("bp_rd4", 128'(bus.rd_o), 128'(4));
        chk("bp_rd4_data", bus.data_o, dat(4));
        chk("bp_occ_back1", 128'(bus.occupancy_o), 128'(1));
        chk("bp_ready1", 128'(bus.ready_o), 128'(1));
        tick();
        chk("bp_rd5", 128'(bus.rd_o), 128'(5));
        chk("bp_rd5_valid", 128'(bus.valid_o), 128'(1));
        idle();
        tick();
        chk("bp_done_valid", 128'(bus.valid_o), 128'(0));

        put(6);
        tick();
        bus.ready_i = 1'b0;
        put(7);
        tick();
        chk("fl_full_occ", 128'(bus.occupancy_o), 128'(2));
        put(9);
        bus.flush_i = 1'b1;
        tick();
        bus.flush_i = 1'b0;
        idle();
        chk("fl_valid", 128'(bus.valid_o), 128'(0));
        chk("fl_occ", 128'(bus.occupancy_o), 128'(0));
        chk("fl_ctrl", 128'(bus.ctrl_o), 128'(0));
        chk("fl_data", bus.data_o, 128'(0));
        chk("fl_ready", 128'(bus.ready_o), 128'(1));
        chk("fl_hold_ctrl", 128'(bus2.ctrl_o), 128'(0));
        chk("fl_hold_occ", 128'(bus2.occupancy_o), 128'(0));
        bus.ready_i = 1'b1;
        tick();
        chk("fl_rd9_not_emitted", 128'(bus.valid_o), 128'(0));

        put(10);
        tick();
        bus.ready_i = 1'b0;
        put(11);
        tick();
        chk("ar_full_occ", 128'(bus.occupancy_o), 128'(2));
        #2;
        rst_ni = 1'b0;
        #1;
        chk_reset("ar_async");
        chk("ar_hold_valid", 128'(bus2.valid_o), 128'(0));
        idle();
        bus.ready_i = 1'b1;
        tick();
        rst_ni = 1'b1;
        tick();
        chk_reset("ar_released");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
